// File: rtl/mmc1_pkg.sv
// Shared definitions for the MMC1 register core: register indexes,
// save-state slots and the decoded views of the ctrl register.
package mmc1_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHR0 = 2'd1;
  localparam logic [1:0] REG_CHR1 = 2'd2;
  localparam logic [1:0] REG_PRG  = 2'd3;

  localparam logic [7:0] SST_SR = 8'd4;

  // ctrl[1:0]: single-screen low/high, vertical, horizontal
  typedef enum logic [1:0] {
    MIR_1LO = 2'd0,
    MIR_1HI = 2'd1,
    MIR_V   = 2'd2,
    MIR_H   = 2'd3
  } mirror_e;

  // ctrl[3:2]: 32KB switching (two encodings), fixed-low, fixed-high
  typedef enum logic [1:0] {
    PRG_32K_A  = 2'd0,
    PRG_32K_B  = 2'd1,
    PRG_FIX_LO = 2'd2,
    PRG_FIX_HI = 2'd3
  } prg_mode_e;

endpackage

// File: rtl/mmc1_serial_loader.sv
// MMC1 serial port: detects CPU write strobes on the M2 falling edge,
// applies the RMW consecutive-write filter and assembles 5-bit values.
module mmc1_serial_loader
  import mmc1_pkg::*;
#(
  parameter bit WR_FILTER = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_m2,
  input  logic       cpu_ce_n,
  input  logic       cpu_rw,
  input  logic       cpu_d7,
  input  logic       cpu_d0,
  input  logic [1:0] cpu_addr,
  input  logic       sst_we,
  input  logic       sst_sr_sel,
  input  logic [2:0] sst_cnt,
  input  logic [3:0] sst_sr,
  output logic       load_stb,
  output logic [1:0] load_idx,
  output logic [4:0] load_data,
  output logic       clr_stb,
  output logic [7:0] sst_sr_q
);

  logic       m2_q;
  logic       last_wr;
  logic [3:0] sr;
  logic [2:0] cnt;

  logic m2_fall;
  logic wr_cyc;
  logic wr_stb;
  logic wr_acc;

  assign m2_fall = m2_q & ~cpu_m2;
  assign wr_cyc  = ~cpu_ce_n & ~cpu_rw;
  // A read-modify-write instruction writes twice on back-to-back M2 cycles;
  // the real chip only honours the first, which games rely on.
  assign wr_stb  = m2_fall & wr_cyc & ~(WR_FILTER & last_wr);
  assign wr_acc  = wr_stb & ~sst_we;

  assign clr_stb   = wr_acc & cpu_d7;
  assign load_stb  = wr_acc & ~cpu_d7 & (cnt == 3'd4);
  assign load_idx  = cpu_addr;
  assign load_data = {cpu_d0, sr};
  assign sst_sr_q  = {cnt, 1'b0, sr};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make ordering inside the block matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      m2_q    <= 1'b0;
      last_wr <= 1'b0;
      sr      <= 4'h0;
      cnt     <= 3'd0;
    end else begin
      m2_q <= cpu_m2;
      if (m2_fall) last_wr <= wr_cyc;

      if (sst_we) begin
        if (sst_sr_sel) begin
          cnt <= sst_cnt;
          sr  <= sst_sr;
        end
      end else if (wr_stb) begin
        if (cpu_d7 || cnt == 3'd4) begin
          sr  <= 4'h0;
          cnt <= 3'd0;
        end else begin
          sr  <= {cpu_d0, sr[3:1]};
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mmc1_reg_core.sv
// MMC1 register core: holds ctrl/chr0/chr1/prg, decodes banked PRG/CHR
// addresses, CIRAM A10 and WRAM enable, and exposes save-state access.
module mmc1_reg_core
  import mmc1_pkg::*;
#(
  parameter bit         WR_FILTER = 1'b1,
  parameter logic [4:0] CTRL_RST  = 5'h0C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cpu_addr,
  input  logic       cpu_d7,
  input  logic       cpu_d0,
  input  logic       cpu_m2,
  input  logic       cpu_ce_n,
  input  logic       cpu_rw,
  input  logic [2:0] ppu_addr,
  output logic       wram_ce,
  output logic       prg_ce_n,
  output logic       ciram_a10,
  output logic [3:0] prg_addr,
  output logic [4:0] chr_addr,
  input  logic [7:0] sst_addr,
  input  logic       sst_we,
  input  logic [7:0] sst_do,
  output logic [7:0] sst_di
);

  logic [4:0] ctrl, chr0, chr1, prg;

  logic       load_stb;
  logic [1:0] load_idx;
  logic [4:0] load_data;
  logic       clr_stb;
  logic [7:0] sst_sr_q;
  logic       sst_reg_sel;

  assign sst_reg_sel = (sst_addr[7:2] == 6'd0);

  mmc1_serial_loader #(.WR_FILTER(WR_FILTER)) u_loader (
    .clk        (clk),
    .rst        (rst),
    .cpu_m2     (cpu_m2),
    .cpu_ce_n   (cpu_ce_n),
    .cpu_rw     (cpu_rw),
    .cpu_d7     (cpu_d7),
    .cpu_d0     (cpu_d0),
    .cpu_addr   (cpu_addr),
    .sst_we     (sst_we),
    .sst_sr_sel (sst_addr == SST_SR),
    .sst_cnt    (sst_do[7:5]),
    .sst_sr     (sst_do[3:0]),
    .load_stb   (load_stb),
    .load_idx   (load_idx),
    .load_data  (load_data),
    .clr_stb    (clr_stb),
    .sst_sr_q   (sst_sr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= CTRL_RST;
      chr0 <= 5'h00;
      chr1 <= 5'h00;
      prg  <= 5'h00;
    end else if (sst_we) begin
      if (sst_reg_sel) begin
        case (sst_addr[1:0])
          REG_CTRL: ctrl <= sst_do[4:0];
          REG_CHR0: chr0 <= sst_do[4:0];
          REG_CHR1: chr1 <= sst_do[4:0];
          REG_PRG:  prg  <= sst_do[4:0];
          default:  ;
        endcase
      end
    end else if (clr_stb) begin
      ctrl <= ctrl | CTRL_RST;
    end else if (load_stb) begin
      case (load_idx)
        REG_CTRL: ctrl <= load_data;
        REG_CHR0: chr0 <= load_data;
        REG_CHR1: chr1 <= load_data;
        REG_PRG:  prg  <= load_data;
        default:  ;
      endcase
    end
  end

  mirror_e   mir;
  prg_mode_e prg_mode;
  logic      a14;

  assign mir      = mirror_e'(ctrl[1:0]);
  assign prg_mode = prg_mode_e'(ctrl[3:2]);
  assign a14      = cpu_addr[1];

  // NOTE: every output of this block gets a default before the case logic,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    ciram_a10 = 1'b0;
    prg_addr  = 4'h0;
    chr_addr  = {chr0[4:1], ppu_addr[2]};

    case (mir)
      MIR_1LO: ciram_a10 = 1'b0;
      MIR_1HI: ciram_a10 = 1'b1;
      MIR_V:   ciram_a10 = ppu_addr[0];
      MIR_H:   ciram_a10 = ppu_addr[1];
      default: ciram_a10 = 1'b0;
    endcase

    if (ctrl[4]) chr_addr = ppu_addr[2] ? chr1 : chr0;

    case (prg_mode)
      PRG_FIX_LO: prg_addr = a14 ? prg[3:0] : 4'h0;
      PRG_FIX_HI: prg_addr = a14 ? 4'hF : prg[3:0];
      default:    prg_addr = {prg[3:1], a14};
    endcase
  end

  assign prg_ce_n = cpu_ce_n;
  assign wram_ce  = cpu_ce_n & (cpu_addr == 2'b11) & ~prg[4];

  always_comb begin
    sst_di = 8'hFF;
    if (sst_reg_sel) begin
      case (sst_addr[1:0])
        REG_CTRL: sst_di = {3'b000, ctrl};
        REG_CHR0: sst_di = {3'b000, chr0};
        REG_CHR1: sst_di = {3'b000, chr1};
        REG_PRG:  sst_di = {3'b000, prg};
        default:  sst_di = 8'hFF;
      endcase
    end else if (sst_addr == SST_SR) begin
      sst_di = sst_sr_q;
    end
  end

endmodule

// File: tb/tb_mmc1_reg_core.sv
// Scoreboard bench for mmc1_reg_core: two instances (filter on/off) share
// stimulus; a reference model predicts every probed output set.
module tb_mmc1_reg_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cpu_addr = 2'd0;
  logic       cpu_d7 = 1'b0;
  logic       cpu_d0 = 1'b0;
  logic       cpu_m2 = 1'b0;
  logic       cpu_ce_n = 1'b1;
  logic       cpu_rw = 1'b1;
  logic [2:0] ppu_addr = 3'd0;
  logic [7:0] sst_addr = 8'd0;
  logic       sst_we = 1'b0;
  logic [7:0] sst_do = 8'd0;

  logic       wram_ce_f, prg_ce_n_f, ciram_a10_f;
  logic [3:0] prg_addr_f;
  logic [4:0] chr_addr_f;
  logic [7:0] sst_di_f;
  logic       wram_ce_n0, prg_ce_n_n0, ciram_a10_n0;
  logic [3:0] prg_addr_n0;
  logic [4:0] chr_addr_n0;
  logic [7:0] sst_di_n0;

  always #5 clk = ~clk;

  mmc1_reg_core #(.WR_FILTER(1'b1), .CTRL_RST(5'h0C)) dut_f (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d7(cpu_d7), .cpu_d0(cpu_d0),
    .cpu_m2(cpu_m2), .cpu_ce_n(cpu_ce_n), .cpu_rw(cpu_rw), .ppu_addr(ppu_addr),
    .wram_ce(wram_ce_f), .prg_ce_n(prg_ce_n_f), .ciram_a10(ciram_a10_f),
    .prg_addr(prg_addr_f), .chr_addr(chr_addr_f),
    .sst_addr(sst_addr), .sst_we(sst_we), .sst_do(sst_do), .sst_di(sst_di_f)
  );

  mmc1_reg_core #(.WR_FILTER(1'b0), .CTRL_RST(5'h0C)) dut_nf (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d7(cpu_d7), .cpu_d0(cpu_d0),
    .cpu_m2(cpu_m2), .cpu_ce_n(cpu_ce_n), .cpu_rw(cpu_rw), .ppu_addr(ppu_addr),
    .wram_ce(wram_ce_n0), .prg_ce_n(prg_ce_n_n0), .ciram_a10(ciram_a10_n0),
    .prg_addr(prg_addr_n0), .chr_addr(chr_addr_n0),
    .sst_addr(sst_addr), .sst_we(sst_we), .sst_do(sst_do), .sst_di(sst_di_n0)
  );

  typedef struct packed {
    logic       wram_ce;
    logic       prg_ce_n;
    logic       ciram_a10;
    logic [3:0] prg_addr;
    logic [4:0] chr_addr;
    logic [7:0] sst_di;
  } obs_t;

  typedef struct packed {
    obs_t e0;
    obs_t e1;
  } item_t;

  item_t sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  probe_req = 1'b0;

  // Reference model state; index 0 = filtered instance, 1 = unfiltered.
  logic [4:0] m_reg [2][4];
  logic [3:0] m_sr  [2];
  logic [2:0] m_cnt [2];
  bit         m_last[2];

  task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_reg[k][0] = 5'h0C;
      m_reg[k][1] = 5'h00;
      m_reg[k][2] = 5'h00;
      m_reg[k][3] = 5'h00;
      m_sr[k]     = 4'h0;
      m_cnt[k]    = 3'd0;
      m_last[k]   = 1'b0;
    end
  endfunction

  function automatic void model_fall(input logic ce_n, input logic rw, input logic [1:0] a,
                                     input logic d7, input logic d0, input bit blocked);
    for (int k = 0; k < 2; k++) begin
      bit is_wr;
      bit acc;
      is_wr = !ce_n && !rw;
      acc   = is_wr && !(k == 0 && m_last[k]) && !blocked;
      m_last[k] = is_wr;
      if (acc) begin
        if (d7) begin
          m_sr[k]     = 4'h0;
          m_cnt[k]    = 3'd0;
          m_reg[k][0] = m_reg[k][0] | 5'h0C;
        end else if (m_cnt[k] == 3'd4) begin
          m_reg[k][a] = {d0, m_sr[k]};
          m_sr[k]     = 4'h0;
          m_cnt[k]    = 3'd0;
        end else begin
          m_sr[k]  = {d0, m_sr[k][3:1]};
          m_cnt[k] = m_cnt[k] + 3'd1;
        end
      end
    end
  endfunction

  function automatic obs_t model_obs(input int k, input logic [7:0] idx);
    obs_t       o;
    logic [4:0] c, c0, c1, p;
    logic       a14;
    c   = m_reg[k][0];
    c0  = m_reg[k][1];
    c1  = m_reg[k][2];
    p   = m_reg[k][3];
    a14 = cpu_addr[1];
    case (c[1:0])
      2'd0:    o.ciram_a10 = 1'b0;
      2'd1:    o.ciram_a10 = 1'b1;
      2'd2:    o.ciram_a10 = ppu_addr[0];
      default: o.ciram_a10 = ppu_addr[1];
    endcase
    o.chr_addr = c[4] ? (ppu_addr[2] ? c1 : c0) : {c0[4:1], ppu_addr[2]};
    case (c[3:2])
      2'd2:    o.prg_addr = a14 ? p[3:0] : 4'h0;
      2'd3:    o.prg_addr = a14 ? 4'hF : p[3:0];
      default: o.prg_addr = {p[3:1], a14};
    endcase
    o.prg_ce_n = cpu_ce_n;
    o.wram_ce  = cpu_ce_n && (cpu_addr == 2'b11) && !p[4];
    if (idx < 8'd4)       o.sst_di = {3'b000, m_reg[k][idx[1:0]]};
    else if (idx == 8'd4) o.sst_di = {m_cnt[k], 1'b0, m_sr[k]};
    else                  o.sst_di = 8'hFF;
    return o;
  endfunction

  // Monitor: consumes one scoreboard entry per presented probe.
  always @(negedge clk) begin
    if (probe_req) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got probe with empty queue, expected entry");
      end else begin
        item_t it;
        obs_t  g[2];
        obs_t  e[2];
        it = sb_q.pop_front();
        e[0] = it.e0;
        e[1] = it.e1;
        g[0] = '{wram_ce_f, prg_ce_n_f, ciram_a10_f, prg_addr_f, chr_addr_f, sst_di_f};
        g[1] = '{wram_ce_n0, prg_ce_n_n0, ciram_a10_n0, prg_addr_n0, chr_addr_n0, sst_di_n0};
        for (int k = 0; k < 2; k++) begin
          check("wram_ce",   k, {7'd0, g[k].wram_ce},   {7'd0, e[k].wram_ce});
          check("prg_ce_n",  k, {7'd0, g[k].prg_ce_n},  {7'd0, e[k].prg_ce_n});
          check("ciram_a10", k, {7'd0, g[k].ciram_a10}, {7'd0, e[k].ciram_a10});
          check("prg_addr",  k, {4'd0, g[k].prg_addr},  {4'd0, e[k].prg_addr});
          check("chr_addr",  k, {3'd0, g[k].chr_addr},  {3'd0, e[k].chr_addr});
          check("sst_di",    k, g[k].sst_di,            e[k].sst_di);
        end
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic probe(input logic [7:0] idx, input bit use_c = 1'b0,
                       input logic [7:0] c0 = 8'h00, input logic [7:0] c1 = 8'h00);
    item_t it;
    sst_addr = idx;
    it.e0 = model_obs(0, idx);
    it.e1 = model_obs(1, idx);
    if (use_c) begin
      it.e0.sst_di = c0;
      it.e1.sst_di = c1;
    end
    sb_q.push_back(it);
    probe_req = 1'b1;
    @(posedge clk); #1;
    probe_req = 1'b0;
  endtask

  task automatic probe_c(input logic [7:0] idx, input logic [7:0] c);
    probe(idx, 1'b1, c, c);
  endtask

  task automatic set_bus(input logic [1:0] a, input logic ce_n, input logic rw, input logic [2:0] ppu);
    cpu_addr = a;
    cpu_ce_n = ce_n;
    cpu_rw   = rw;
    ppu_addr = ppu;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic m2_cycle(input logic ce_n, input logic rw, input logic [1:0] a,
                          input logic d7, input logic d0,
                          input bit lat = 1'b0, input bit sst_hit = 1'b0);
    @(posedge clk); #1;
    cpu_ce_n = ce_n;
    cpu_rw   = rw;
    cpu_addr = a;
    cpu_d7   = d7;
    cpu_d0   = d0;
    cpu_m2   = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    cpu_m2 = 1'b0;
    if (sst_hit) begin
      sst_addr = 8'd7;
      sst_do   = 8'hA5;
      sst_we   = 1'b1;
    end
    if (lat) probe(8'd3);
    else begin @(posedge clk); #1; end
    sst_we = 1'b0;
    model_fall(ce_n, rw, a, d7, d0, sst_hit);
    if (lat) probe(8'd3);
    cpu_ce_n = 1'b1;
    cpu_rw   = 1'b1;
  endtask

  // A write followed by a read cycle, so the RMW filter never fires.
  task automatic wr(input logic [1:0] a, input logic d7, input logic d0, input bit lat = 1'b0);
    m2_cycle(1'b0, 1'b0, a, d7, d0, lat);
    m2_cycle(1'b0, 1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic write5(input logic [1:0] a, input logic [4:0] v);
    logic [4:0] vv;
    vv = v;
    for (int i = 0; i < 5; i++) wr(a, 1'b0, vv[i]);
  endtask

  task automatic sst_write(input logic [7:0] idx, input logic [7:0] data);
    sst_addr = idx;
    sst_do   = data;
    sst_we   = 1'b1;
    @(posedge clk); #1;
    sst_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (idx < 8'd4) m_reg[k][idx[1:0]] = data[4:0];
      else if (idx == 8'd4) begin
        m_cnt[k] = data[7:5];
        m_sr[k]  = data[3:0];
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Reset state: $C000, PPU $1xxx
    set_bus(2'd2, 1'b0, 1'b1, 3'b100);
    probe_c(8'd0, 8'h0C);
    probe_c(8'd4, 8'h00);

    // Five writes to $E000: d0 = 1,0,1,0,0; the 5th checks load latency
    wr(2'd3, 1'b0, 1'b1);
    wr(2'd3, 1'b0, 1'b0);
    wr(2'd3, 1'b0, 1'b1);
    wr(2'd3, 1'b0, 1'b0);
    wr(2'd3, 1'b0, 1'b0, 1'b1);
    set_bus(2'd0, 1'b0, 1'b1, 3'b000);
    probe_c(8'd3, 8'h05);

    // ctrl = 13, chr0 = 06, chr1 = 0B; PPU $0400 and $1800
    write5(2'd0, 5'h13);
    write5(2'd1, 5'h06);
    write5(2'd2, 5'h0B);
    set_bus(2'd0, 1'b0, 1'b1, 3'b001);
    probe_c(8'd0, 8'h13);
    set_bus(2'd0, 1'b0, 1'b1, 3'b110);
    probe_c(8'd1, 8'h06);
    probe_c(8'd2, 8'h0B);

    // Two writes then D7: sr/cnt clear, ctrl |= 0C; then a normal load
    wr(2'd0, 1'b0, 1'b1);
    wr(2'd0, 1'b0, 1'b1);
    wr(2'd0, 1'b1, 1'b0);
    probe_c(8'd4, 8'h00);
    probe_c(8'd0, 8'h1F);
    write5(2'd0, 5'h13);
    probe_c(8'd0, 8'h13);

    // D7 on the 5th slot clears without loading
    for (int i = 0; i < 4; i++) wr(2'd1, 1'b0, 1'b1);
    wr(2'd1, 1'b1, 1'b1);
    probe_c(8'd4, 8'h00);
    probe_c(8'd1, 8'h06);

    // RMW back-to-back writes
    do_reset();
    m2_cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    m2_cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    m2_cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    probe(8'd4, 1'b1, 8'h28, 8'h4C);

    // Save-state write colliding with a write strobe discards the write
    do_reset();
    wr(2'd1, 1'b0, 1'b1);
    m2_cycle(1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    m2_cycle(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    probe_c(8'd4, 8'h28);

    // Save-state round trip, then commit on the cnt = 4 write
    sst_write(8'd4, 8'h65);
    probe_c(8'd4, 8'h65);
    wr(2'd3, 1'b0, 1'b1);
    probe_c(8'd4, 8'h8A);
    wr(2'd3, 1'b0, 1'b0);
    probe_c(8'd3, 8'h0A);
    probe_c(8'd4, 8'h00);

    // Reset at cnt = 3 aborts the load
    for (int i = 0; i < 3; i++) wr(2'd3, 1'b0, 1'b1);
    probe_c(8'd4, 8'h6E);
    do_reset();
    probe_c(8'd4, 8'h00);
    probe_c(8'd3, 8'h00);
    probe_c(8'd0, 8'h0C);
    probe_c(8'd9, 8'hFF);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [1:0] ra;
      ra = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wr(ra, ($urandom_range(0, 7) == 0), 1'($urandom));
        4: begin
          m2_cycle(1'b0, 1'b0, ra, 1'b0, 1'($urandom));
          m2_cycle(1'b0, 1'b0, ra, 1'b0, 1'($urandom));
          m2_cycle(1'b0, 1'b1, ra, 1'b0, 1'b0);
        end
        5: m2_cycle(1'b1, 1'($urandom), ra, 1'($urandom), 1'($urandom));
        6: begin
          logic [7:0] idx;
          logic [7:0] d;
          idx = 8'($urandom_range(0, 7));
          d   = 8'($urandom);
          if (idx == 8'd4) d[7:5] = 3'($urandom_range(0, 4));
          sst_write(idx, d);
        end
        8: begin
          if ($urandom_range(0, 7) == 0) do_reset();
          set_bus(ra, 1'($urandom), 1'($urandom), 3'($urandom));
          probe(8'($urandom_range(0, 4)));
        end
        default: begin
          set_bus(ra, 1'($urandom), 1'($urandom), 3'($urandom));
          probe(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4)));
        end
      endcase
    end

    @(posedge clk); #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
